lane_recorder: RTL and testbench

Writer side of the lane memory consumed by the game datapath. It records a player's button presses, one bit per lane-clock slot, into a LANE_LEN-bit pattern that the datapath then plays back.
- Bit order matches playback: the datapath shifts right and scores bit 0 first, so the first recorded slot ends at bit 0.
- Sits beside the datapath in the top level. Shares the lane clock from note_rate_div and the active-high press signal derived from the lane GPIO.

---
 rtl/lane_recorder_pkg.sv | 20 ++
 rtl/lane_recorder_edge_sync.sv | 49 ++++
 rtl/lane_recorder.sv | 150 +++++++++++++++
 tb/tb_lane_recorder.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lane_recorder_pkg.sv
// Shared definitions for the lane recorder.
//   LaneLenDefault : default lane pattern width, shared with the datapath lane width.
//   lane_state_e   : recorder FSM encoding (IDLE=0, ARM=1, REC=2, DONE=3).
//   is_recording   : true in the states that drive the 'recording' output.
package lane_recorder_pkg;

  localparam int unsigned LaneLenDefault = 100;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StArm  = 2'd1,
    StRec  = 2'd2,
    StDone = 2'd3
  } lane_state_e;

  function automatic logic is_recording(input lane_state_e s);
    return (s == StArm) || (s == StRec);
  endfunction

endpackage

// File: rtl/lane_recorder_edge_sync.sv
// Optional synchroniser chain followed by a rising-edge detector.
//   clk_i  : system clock
//   rst_i  : synchronous reset, active-high
//   sig_i  : raw input (may be asynchronous when Stages > 0)
//   rise_o : one-cycle pulse when the synchronised input goes 0 -> 1
// With Stages = 0 the input is assumed already synchronous and only the
// previous-value register is kept.
module lane_recorder_edge_sync #(
  parameter int unsigned Stages = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig_i,
  output logic rise_o
);

  logic synced;
  logic prev_q;

  if (Stages == 0) begin : g_nosync
    assign synced = sig_i;
  end else begin : g_sync
    logic [Stages-1:0] stage_q;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        stage_q <= '0;
      end else begin
        stage_q[0] <= sig_i;
        for (int unsigned i = 1; i < Stages; i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end

    assign synced = stage_q[Stages-1];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= synced;
    end
  end

  assign rise_o = synced & ~prev_q;

endmodule

// File: rtl/lane_recorder.sv
// Records button presses, one bit per lane-clock slot, into a LANE_LEN-bit
// pattern for the game datapath. The first recorded slot ends at bit 0 so
// playback (shift right, score bit 0) replays in recording order.
//   clk       : system clock
//   resetn    : synchronous reset, active-HIGH despite the name
//   lane_clk  : lane square wave; each rising edge closes a slot
//   press     : active-high button, asynchronous to clk
//   record_en : 1 = arm/record, 0 = abort or release a finished pattern
//   lane_mem  : recorded pattern
//   recording : high while arming or recording
//   done      : high while a complete pattern is held
//   slot_cnt  : slots closed so far
//   note_cnt  : number of 1-bits in lane_mem
module lane_recorder
  import lane_recorder_pkg::*;
#(
  parameter int unsigned LANE_LEN    = LaneLenDefault,
  parameter int unsigned CNT_W       = 7,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                lane_clk,
  input  logic                press,
  input  logic                record_en,
  output logic [LANE_LEN-1:0] lane_mem,
  output logic                recording,
  output logic                done,
  output logic [CNT_W-1:0]    slot_cnt,
  output logic [CNT_W-1:0]    note_cnt
);

  localparam logic [CNT_W-1:0] LastSlot = CNT_W'(LANE_LEN - 1);

  lane_state_e         state_q, state_d;
  logic [LANE_LEN-1:0] mem_q, mem_d;
  logic [CNT_W-1:0]    slot_q, slot_d;
  logic [CNT_W-1:0]    note_q, note_d;
  logic                hit_q, hit_d;
  logic                press_edge;
  logic                lane_tick;
  logic                slot_bit;

  lane_recorder_edge_sync #(
    .Stages (SYNC_STAGES)
  ) u_press_sync (
    .clk_i  (clk),
    .rst_i  (resetn),
    .sig_i  (press),
    .rise_o (press_edge)
  );

  // lane_clk comes from the same clock domain, so only the edge detector is needed.
  lane_recorder_edge_sync #(
    .Stages (0)
  ) u_lane_sync (
    .clk_i  (clk),
    .rst_i  (resetn),
    .sig_i  (lane_clk),
    .rise_o (lane_tick)
  );

  // An edge arriving together with the closing tick still belongs to the closing slot.
  assign slot_bit = hit_q | press_edge;

  always_comb begin
    state_d = state_q;
    mem_d   = mem_q;
    slot_d  = slot_q;
    note_d  = note_q;
    hit_d   = hit_q;

    case (state_q)
      StIdle: begin
        if (record_en) begin
          mem_d   = '0;
          slot_d  = '0;
          note_d  = '0;
          hit_d   = 1'b0;
          state_d = StArm;
        end
      end

      StArm: begin
        if (!record_en) begin
          mem_d   = '0;
          slot_d  = '0;
          note_d  = '0;
          hit_d   = 1'b0;
          state_d = StIdle;
        end else if (lane_tick) begin
          // Alignment tick only: slot 0 starts here.
          state_d = StRec;
        end
      end

      StRec: begin
        // Abort has priority, including over the final closing tick.
        if (!record_en) begin
          mem_d   = '0;
          slot_d  = '0;
          note_d  = '0;
          hit_d   = 1'b0;
          state_d = StIdle;
        end else if (lane_tick) begin
          mem_d  = {slot_bit, mem_q[LANE_LEN-1:1]};
          slot_d = slot_q + CNT_W'(1);
          note_d = note_q + CNT_W'(slot_bit);
          hit_d  = 1'b0;
          if (slot_q == LastSlot) begin
            state_d = StDone;
          end
        end else if (press_edge) begin
          hit_d = 1'b1;
        end
      end

      StDone: begin
        if (!record_en) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q <= StIdle;
      mem_q   <= '0;
      slot_q  <= '0;
      note_q  <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mem_q   <= mem_d;
      slot_q  <= slot_d;
      note_q  <= note_d;
      hit_q   <= hit_d;
    end
  end

  assign lane_mem  = mem_q;
  assign slot_cnt  = slot_q;
  assign note_cnt  = note_q;
  assign recording = is_recording(state_q);
  assign done      = (state_q == StDone);

endmodule

// File: tb/tb_lane_recorder.sv
// Bench for lane_recorder: an 8-slot instance for the table and corner cases,
// and a default-size instance for the full-length recording.
module tb_lane_recorder;

  logic        clk = 1'b0;
  logic        resetn;
  logic        lane_clk;
  logic        press;
  logic        rec8;
  logic        rec100;

  logic [7:0]  mem8;
  logic        recording8, done8;
  logic [6:0]  slot8, note8;
  logic [99:0] mem100;
  logic        recording100, done100;
  logic [6:0]  slot100, note100;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string       name;
    logic [99:0] mem;
    int          notes;
    int          slots;
    bit          big;
  } exp_t;

  typedef struct {
    string      name;
    logic [7:0] presses;
    logic [7:0] exp_mem;
    int         exp_notes;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[4];

  always #5 clk = ~clk;

  lane_recorder #(
    .LANE_LEN    (8),
    .CNT_W       (7),
    .SYNC_STAGES (2)
  ) dut8 (
    .clk       (clk),
    .resetn    (resetn),
    .lane_clk  (lane_clk),
    .press     (press),
    .record_en (rec8),
    .lane_mem  (mem8),
    .recording (recording8),
    .done      (done8),
    .slot_cnt  (slot8),
    .note_cnt  (note8)
  );

  lane_recorder #(
    .LANE_LEN    (100),
    .CNT_W       (7),
    .SYNC_STAGES (2)
  ) dut100 (
    .clk       (clk),
    .resetn    (resetn),
    .lane_clk  (lane_clk),
    .press     (press),
    .record_en (rec100),
    .lane_mem  (mem100),
    .recording (recording100),
    .done      (done100),
    .slot_cnt  (slot100),
    .note_cnt  (note100)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick();
    lane_clk = 1'b1;
    cyc(2);
    lane_clk = 1'b0;
    cyc(2);
  endtask

  task automatic press_pulse();
    press = 1'b1;
    cyc(4);
    press = 1'b0;
    cyc(3);
  endtask

  task automatic slot(input bit p);
    if (p) press_pulse();
    else cyc(2);
    tick();
  endtask

  task automatic expect_rec(input string name, input logic [99:0] mem, input int notes,
                            input int slots, input bit big);
    exp_t e;
    e.name  = name;
    e.mem   = mem;
    e.notes = notes;
    e.slots = slots;
    e.big   = big;
    sb.push_back(e);
  endtask

  // Arm the selected instance, confirm the cleared ARM state, then send the alignment tick.
  task automatic arm(input bit big);
    if (big) rec100 = 1'b1;
    else rec8 = 1'b1;
    cyc(1);
    check("arm_recording", big ? recording100 : recording8, 1'b1);
    check("arm_mem_clear", big ? mem100 : {92'b0, mem8}, '0);
    check("arm_slot_clear", big ? slot100 : slot8, '0);
    check("arm_done_low", big ? done100 : done8, 1'b0);
    tick();
  endtask

  task automatic finish_rec(input bit big);
    exp_t        e;
    logic [99:0] cur;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_empty: got 0 entries, expected 1");
      return;
    end
    e = sb.pop_front();
    for (int i = 0; i < 40 && !(big ? done100 : done8); i++) cyc(1);
    check({e.name, "_done"}, big ? done100 : done8, 1'b1);
    check({e.name, "_recording"}, big ? recording100 : recording8, 1'b0);
    cur = big ? mem100 : {92'b0, mem8};
    check({e.name, "_mem"}, cur, e.mem);
    check({e.name, "_notes"}, big ? note100 : note8, e.notes);
    check({e.name, "_slots"}, big ? slot100 : slot8, e.slots);
    // Press and tick while DONE: pattern must stay frozen.
    slot(1'b1);
    cur = big ? mem100 : {92'b0, mem8};
    check({e.name, "_frozen"}, cur, e.mem);
    if (big) rec100 = 1'b0;
    else rec8 = 1'b0;
    cyc(1);
    check({e.name, "_release_done"}, big ? done100 : done8, 1'b0);
    cur = big ? mem100 : {92'b0, mem8};
    check({e.name, "_release_kept"}, cur, e.mem);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [99:0] big_mem;

    resetn   = 1'b1;
    lane_clk = 1'b0;
    press    = 1'b0;
    rec8     = 1'b0;
    rec100   = 1'b0;
    cyc(3);
    resetn = 1'b0;
    cyc(1);
    check("reset_mem", mem8, 8'h00);
    check("reset_recording", recording8, 1'b0);
    check("reset_done", done8, 1'b0);
    check("reset_slot", slot8, 7'd0);
    check("reset_note", note8, 7'd0);
    check("reset_done100", done100, 1'b0);

    // Table: press pattern per slot (bit i = slot i) and expected lane_mem.
    vecs[0] = '{"slots_0_2_7", 8'b1000_0101, 8'b1000_0101, 3};
    vecs[1] = '{"alternating", 8'b0101_0101, 8'b0101_0101, 4};
    vecs[2] = '{"empty",       8'b0000_0000, 8'b0000_0000, 0};
    vecs[3] = '{"all_slots",   8'b1111_1111, 8'b1111_1111, 8};

    for (int v = 0; v < 4; v++) begin
      expect_rec(vecs[v].name, {92'b0, vecs[v].exp_mem}, vecs[v].exp_notes, 8, 1'b0);
      arm(1'b0);
      for (int s = 0; s < 8; s++) begin
        if (s == 7) check({vecs[v].name, "_not_done_early"}, done8, 1'b0);
        slot(vecs[v].presses[s]);
      end
      finish_rec(1'b0);
    end

    // Several presses in slot 0, one press held across slots 1-2.
    expect_rec("multi_press", {92'b0, 8'b0000_0011}, 2, 8, 1'b0);
    arm(1'b0);
    repeat (3) press_pulse();
    tick();
    check("multi_press_slot0_note", note8, 7'd1);
    press = 1'b1;
    cyc(4);
    tick();
    cyc(2);
    press = 1'b0;
    cyc(3);
    tick();
    check("multi_press_held_note", note8, 7'd2);
    for (int s = 3; s < 8; s++) slot(1'b0);
    finish_rec(1'b0);

    // Press edge lands in the same cycle as the tick closing slot 4.
    expect_rec("simultaneous", {92'b0, 8'b0001_0000}, 1, 8, 1'b0);
    arm(1'b0);
    for (int s = 0; s < 4; s++) slot(1'b0);
    cyc(2);
    press = 1'b1;
    cyc(2);
    lane_clk = 1'b1;
    cyc(1);
    check("simul_note", note8, 7'd1);
    check("simul_slot", slot8, 7'd5);
    cyc(1);
    lane_clk = 1'b0;
    cyc(2);
    press = 1'b0;
    cyc(3);
    tick();
    check("simul_slot5_empty_note", note8, 7'd1);
    for (int s = 6; s < 8; s++) slot(1'b0);
    finish_rec(1'b0);

    // Abort at slot_cnt = 5, then a clean re-record.
    arm(1'b0);
    for (int s = 0; s < 5; s++) slot(s[0] == 1'b0);
    check("abort_pre_slot", slot8, 7'd5);
    rec8 = 1'b0;
    cyc(1);
    check("abort_recording", recording8, 1'b0);
    check("abort_mem", mem8, 8'h00);
    check("abort_slot", slot8, 7'd0);
    check("abort_note", note8, 7'd0);
    check("abort_done", done8, 1'b0);
    expect_rec("rerecord", {92'b0, 8'b1100_0001}, 3, 8, 1'b0);
    arm(1'b0);
    for (int s = 0; s < 8; s++) slot(s == 0 || s == 6 || s == 7);
    finish_rec(1'b0);

    // Abort in the same cycle as the final closing tick.
    arm(1'b0);
    for (int s = 0; s < 7; s++) slot(1'b1);
    lane_clk = 1'b1;
    rec8     = 1'b0;
    cyc(1);
    check("final_abort_done", done8, 1'b0);
    check("final_abort_mem", mem8, 8'h00);
    check("final_abort_note", note8, 7'd0);
    check("final_abort_recording", recording8, 1'b0);
    lane_clk = 1'b0;
    cyc(2);

    // Reset in the middle of a recording.
    arm(1'b0);
    for (int s = 0; s < 3; s++) slot(1'b1);
    check("midrec_slot", slot8, 7'd3);
    resetn = 1'b1;
    cyc(1);
    check("midrec_reset_mem", mem8, 8'h00);
    check("midrec_reset_slot", slot8, 7'd0);
    check("midrec_reset_note", note8, 7'd0);
    check("midrec_reset_recording", recording8, 1'b0);
    resetn = 1'b0;
    rec8   = 1'b0;
    cyc(2);

    // Default size: press every third slot.
    big_mem = '0;
    for (int i = 0; i < 100; i++) big_mem[i] = (i % 3 == 0);
    expect_rec("len100", big_mem, 34, 100, 1'b1);
    arm(1'b1);
    for (int s = 0; s < 100; s++) begin
      if (s == 99) check("len100_not_done_early", done100, 1'b0);
      slot(s % 3 == 0);
    end
    finish_rec(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
